// File: rtl/cipher_stream_sequencer.sv
// Stream-cipher message sequencer: pulses keystream init, discards warm-up steps, then XORs each
// accepted input byte with the live keystream byte into a one-entry output register.
module cipher_stream_sequencer #(
  parameter int DATA_W       = 8,
  parameter int LEN_W        = 8,
  parameter int WARMUP_STEPS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              clear,
  output logic              ks_init,
  output logic              ks_step,
  input  logic [DATA_W-1:0] ks_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  byte_count
);

  localparam int                WARM_W    = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS + 1) : 1;
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_STEPS);
  localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WARMUP,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state, state_next;
  logic [LEN_W-1:0]  len_q;
  logic [WARM_W-1:0] warm_q;
  logic              accept;
  logic              pop;
  logic              last_byte;

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    ks_init    = 1'b0;
    ks_step    = 1'b0;
    in_ready   = 1'b0;
    accept     = 1'b0;
    pop        = out_valid && out_ready;
    last_byte  = (byte_count + LEN_W'(1)) == len_q;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = (msg_len == '0) ? S_DONE : S_INIT;
      end
      S_INIT: begin
        ks_init    = 1'b1;
        state_next = (WARMUP_STEPS == 0) ? S_STREAM : S_WARMUP;
      end
      S_WARMUP: begin
        ks_step = 1'b1;
        if (warm_q == WARM_ONE) state_next = S_STREAM;
      end
      S_STREAM: begin
        // The output register is a single slot: take a byte only if it is empty or draining now.
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        ks_step  = accept;
        if (accept && last_byte) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!out_valid || out_ready) state_next = S_DONE;
      end
      S_DONE: begin
        if (clear) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      warm_q     <= '0;
      byte_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= msg_len;
            byte_count <= '0;
          end
        end
        S_INIT:   warm_q <= WARM_LOAD;
        S_WARMUP: warm_q <= warm_q - WARM_ONE;
        default:  ;
      endcase

      // A same-cycle accept and pop keeps out_valid high with the new byte.
      if (accept) begin
        out_data   <= in_data ^ ks_byte;
        out_valid  <= 1'b1;
        byte_count <= byte_count + LEN_W'(1);
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_cipher_stream_sequencer.sv
// Self-checking bench for cipher_stream_sequencer: one instance with 16 warm-up steps, one with none,
// each fed by an LFSR keystream generator; outputs compared to a message-level keystream model.
`timescale 1ns/1ps
module tb_cipher_stream_sequencer;

  localparam int         W    = 16;
  localparam logic [7:0] SEED = 8'h3C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start_z = 1'b0, clear = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] msg_len = '0, in_data = '0;
  logic       ks_const = 1'b0;

  logic       ks_init, ks_step, in_ready, out_valid, busy, done;
  logic [7:0] out_data, byte_count, ks_byte;
  logic       ks_init_z, ks_step_z, in_ready_z, out_valid_z, busy_z, done_z;
  logic [7:0] out_data_z, byte_count_z, ks_byte_z;

  logic [7:0] ks_state = '0, ks_state_z = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_init = 0, n_step = 0, n_init_z = 0, n_step_z = 0;
  int last_pop_cyc = 0, done_rise_cyc = 0, start_cyc = 0, first_acc_cyc = -1;
  logic done_d = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] got_z_q[$];
  logic [7:0] msg[$];

  always #5 clk = ~clk;

  cipher_stream_sequencer #(.DATA_W(8), .LEN_W(8), .WARMUP_STEPS(W)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .clear(clear),
    .ks_init(ks_init), .ks_step(ks_step), .ks_byte(ks_byte),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .byte_count(byte_count)
  );

  cipher_stream_sequencer #(.DATA_W(8), .LEN_W(8), .WARMUP_STEPS(0)) dut_z (
    .clk(clk), .rst(rst), .start(start_z), .msg_len(msg_len), .clear(clear),
    .ks_init(ks_init_z), .ks_step(ks_step_z), .ks_byte(ks_byte_z),
    .in_valid(in_valid), .in_ready(in_ready_z), .in_data(in_data),
    .out_valid(out_valid_z), .out_ready(out_ready), .out_data(out_data_z),
    .busy(busy_z), .done(done_z), .byte_count(byte_count_z)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  // Keystream byte after k generator steps from a fresh init.
  function automatic logic [7:0] ks_at(input int k);
    logic [7:0] x = SEED;
    for (int i = 0; i < k; i++) x = lfsr_next(x);
    return x;
  endfunction

  assign ks_byte   = ks_const ? 8'hA5 : ks_state;
  assign ks_byte_z = ks_state_z;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ks_init)        ks_state <= SEED;
    else if (ks_step)   ks_state <= lfsr_next(ks_state);
    if (ks_init_z)      ks_state_z <= SEED;
    else if (ks_step_z) ks_state_z <= lfsr_next(ks_state_z);
  end

  always @(negedge clk) begin
    done_d <= done;
    if (ks_init)   n_init   <= n_init + 1;
    if (ks_step)   n_step   <= n_step + 1;
    if (ks_init_z) n_init_z <= n_init_z + 1;
    if (ks_step_z) n_step_z <= n_step_z + 1;
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      last_pop_cyc <= cyc;
    end
    if (out_valid_z && out_ready) got_z_q.push_back(out_data_z);
    if (done && !done_d) done_rise_cyc <= cyc;
    if (start && !busy) begin
      start_cyc     <= cyc;
      first_acc_cyc <= -1;
    end else if (in_valid && in_ready && first_acc_cyc < 0) begin
      first_acc_cyc <= cyc;
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    @(posedge clk); #1;
    start = 1'b0; start_z = 1'b0; clear = 1'b0;
    in_valid = v; in_data = d; out_ready = r;
    @(negedge clk);
  endtask

  task automatic pulse_start(input bit sel, input logic [7:0] len);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; msg_len = len;
    if (sel) start_z = 1'b1;
    else     start   = 1'b1;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    start = 1'b0; start_z = 1'b0; clear = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Presents msg[first..] in order until done, optionally with random valid/ready gaps.
  task automatic run_stream(input bit sel, input bit rnd, input int first, input int budget,
                            output bit timed_out);
    int idx = first;
    int n = 0;
    timed_out = 1'b0;
    forever begin
      @(posedge clk); #1;
      start = 1'b0; start_z = 1'b0; clear = 1'b0;
      in_valid  = (idx < msg.size()) && (!rnd || $urandom_range(0, 3) != 0);
      in_data   = (idx < msg.size()) ? msg[idx] : 8'($urandom);
      out_ready = !rnd || $urandom_range(0, 2) != 0;
      @(negedge clk);
      if (in_valid && (sel ? in_ready_z : in_ready)) idx++;
      if (sel ? done_z : done) break;
      n++;
      if (n > budget) begin
        timed_out = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, out_valid, ks_init, ks_step, in_ready} !== 6'b0)
      begin errors++; $display("FAIL reset_flags: got %b expected 000000",
                               {busy, done, out_valid, ks_init, ks_step, in_ready}); end
    checks++;
    if (out_data !== 8'h00 || byte_count !== 8'h00)
      begin errors++; $display("FAIL reset_regs: got data=%h count=%0d expected 00/0", out_data, byte_count); end
    checks++;
    if (busy_z !== 1'b0 || out_valid_z !== 1'b0)
      begin errors++; $display("FAIL reset_z: got busy=%b ov=%b expected 0/0", busy_z, out_valid_z); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_zero_len();
    int b_i = n_init, b_s = n_step;
    pulse_start(0, 8'd0);
    drive(0, 8'h00, 1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL zero_len_done: got done=%b busy=%b expected 1/1", done, busy); end
    @(posedge clk); #1;
    clear = 1'b1;
    drive(0, 8'h00, 1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL zero_len_clear: got done=%b busy=%b expected 0/0", done, busy); end
    checks++;
    if (n_init != b_i || n_step != b_s)
      begin errors++; $display("FAIL zero_len_pulses: got init=%0d step=%0d expected 0/0",
                               n_init - b_i, n_step - b_s); end
  endtask

  task automatic test_directed();
    logic [7:0] exp_d [3] = '{8'hA5, 8'h5A, 8'hFF};
    int b_i = n_init, b_s = n_step;
    bit to;
    ks_const = 1'b1;
    msg = {8'h00, 8'hFF, 8'h5A};
    got_q.delete();
    pulse_start(0, 8'd3);
    run_stream(0, 0, 0, 100, to);
    checks++;
    if (to) begin errors++; $display("FAIL directed_timeout: got no done expected done"); end
    checks++;
    if (got_q.size() != 3)
      begin errors++; $display("FAIL directed_count: got %0d bytes expected 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_d[i])
        begin errors++; $display("FAIL directed_data[%0d]: got %h expected %h", i, got_q[i], exp_d[i]); end
    end
    checks++;
    if (n_init - b_i != 1 || n_step - b_s != 19)
      begin errors++; $display("FAIL directed_pulses: got init=%0d step=%0d expected 1/19",
                               n_init - b_i, n_step - b_s); end
    checks++;
    if (first_acc_cyc != start_cyc + 2 + W)
      begin errors++; $display("FAIL directed_latency: got %0d expected %0d",
                               first_acc_cyc - start_cyc, 2 + W); end
    checks++;
    if (done_rise_cyc != last_pop_cyc + 1)
      begin errors++; $display("FAIL directed_done_lag: got %0d expected 1", done_rise_cyc - last_pop_cyc); end
    pulse_clear();
    ks_const = 1'b0;
  endtask

  task automatic test_backpressure();
    int b_s = n_step;
    int idx = 0;
    bit to;
    logic [7:0] held;
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
    got_q.delete();
    held = msg[0] ^ ks_at(W);
    pulse_start(0, 8'd5);
    for (int n = 0; n < 40 && idx == 0; n++) begin
      drive(1, msg[0], 1);
      if (in_valid && in_ready) idx = 1;
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, msg[1], 0);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ks_step !== 1'b0)
        begin errors++; $display("FAIL stall_ctrl[%0d]: got ov=%b ir=%b step=%b expected 1/0/0",
                                 k, out_valid, in_ready, ks_step); end
      checks++;
      if (out_data !== held)
        begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", k, out_data, held); end
    end
    run_stream(0, 0, 1, 100, to);
    checks++;
    if (to || got_q.size() != 5)
      begin errors++; $display("FAIL stall_count: got %0d bytes timeout=%0b expected 5/0", got_q.size(), to); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== (msg[i] ^ ks_at(W + i)))
        begin errors++; $display("FAIL stall_data_out[%0d]: got %h expected %h", i, got_q[i], msg[i] ^ ks_at(W + i)); end
    end
    checks++;
    if (n_step - b_s != W + 5)
      begin errors++; $display("FAIL stall_steps: got %0d expected %0d", n_step - b_s, W + 5); end
  endtask

  // Entered with the 16-step instance sitting in DONE.
  task automatic test_clear_start();
    int b_i = n_init;
    bit left_idle = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1; start = 1'b1; msg_len = 8'd3;
    drive(0, 8'h00, 1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL clear_start_idle: got busy=%b done=%b expected 0/0", busy, done); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'h00, 1);
      if (busy !== 1'b0) left_idle = 1'b1;
    end
    checks++;
    if (left_idle || n_init != b_i)
      begin errors++; $display("FAIL clear_start_lost: got left_idle=%0b init=%0d expected 0/0",
                               left_idle, n_init - b_i); end
  endtask

  task automatic test_warmup_zero();
    int b_i = n_init_z, b_s = n_step_z;
    logic [7:0] m = 8'($urandom);
    bit seen_done = 1'b0;
    got_z_q.delete();
    pulse_start(1, 8'd1);
    drive(1, m, 1);
    checks++;
    if (ks_init_z !== 1'b1 || in_ready_z !== 1'b0)
      begin errors++; $display("FAIL w0_init: got init=%b ir=%b expected 1/0", ks_init_z, in_ready_z); end
    drive(1, m, 1);
    checks++;
    if (in_ready_z !== 1'b1 || ks_step_z !== 1'b1)
      begin errors++; $display("FAIL w0_stream: got ir=%b step=%b expected 1/1", in_ready_z, ks_step_z); end
    for (int n = 0; n < 10 && !seen_done; n++) begin
      drive(0, 8'h00, 1);
      seen_done = done_z;
    end
    @(posedge clk); #1;
    checks++;
    if (!seen_done || got_z_q.size() != 1)
      begin errors++; $display("FAIL w0_done: got done=%0b bytes=%0d expected 1/1", seen_done, got_z_q.size()); end
    else begin
      checks++;
      if (got_z_q[0] !== (m ^ ks_at(0)))
        begin errors++; $display("FAIL w0_data: got %h expected %h", got_z_q[0], m ^ ks_at(0)); end
    end
    checks++;
    if (n_init_z - b_i != 1 || n_step_z - b_s != 1)
      begin errors++; $display("FAIL w0_pulses: got init=%0d step=%0d expected 1/1",
                               n_init_z - b_i, n_step_z - b_s); end
    pulse_clear();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      int len = $urandom_range(1, 12);
      int b_i = n_init, b_s = n_step;
      bit to;
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      got_q.delete();
      pulse_start(0, 8'(len));
      run_stream(0, 1, 0, 400, to);
      checks++;
      if (to || got_q.size() != len)
        begin errors++; $display("FAIL b2b[%0d]_count: got %0d bytes timeout=%0b expected %0d/0",
                                 t, got_q.size(), to, len); end
      for (int i = 0; i < len && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== (msg[i] ^ ks_at(W + i)))
          begin errors++; $display("FAIL b2b[%0d]_data[%0d]: got %h expected %h",
                                   t, i, got_q[i], msg[i] ^ ks_at(W + i)); end
      end
      checks++;
      if (n_init - b_i != 1 || n_step - b_s != W + len)
        begin errors++; $display("FAIL b2b[%0d]_pulses: got init=%0d step=%0d expected 1/%0d",
                                 t, n_init - b_i, n_step - b_s, W + len); end
      checks++;
      if (done !== 1'b1 || byte_count !== 8'(len))
        begin errors++; $display("FAIL b2b[%0d]_final: got done=%b count=%0d expected 1/%0d",
                                 t, done, byte_count, len); end
      @(posedge clk); #1;
      clear = 1'b1;
    end
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    bit done_seen = 1'b0;
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
    pulse_start(0, 8'd5);
    for (int n = 0; n < 40 && byte_count != 8'd2; n++) begin
      drive(1, msg[idx], 1);
      if (in_valid && in_ready && idx < 4) idx++;
    end
    checks++;
    if (busy !== 1'b1 || byte_count !== 8'd2)
      begin errors++; $display("FAIL rst_mid_pre: got busy=%b count=%0d expected 1/2", busy, byte_count); end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || byte_count !== 8'd0 || done !== 1'b0)
      begin errors++; $display("FAIL rst_mid: got busy=%b ov=%b count=%0d done=%b expected 0/0/0/0",
                               busy, out_valid, byte_count, done); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      drive(0, 8'h00, 1);
      if (done || busy) done_seen = 1'b1;
    end
    checks++;
    if (done_seen)
      begin errors++; $display("FAIL rst_mid_after: got activity after reset expected idle"); end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_directed();
    test_backpressure();
    test_clear_start();
    test_warmup_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected completion within 1ms");
    $fatal(1, "simulation time limit reached");
  end

endmodule
